// File: rtl/ctrl_fsm_multicycle_if.sv
// Control/status bundle between the multi-cycle control unit and the 16-bit RISC datapath.
// master = control unit, slave = datapath/memory side.
interface ctrl_fsm_multicycle_if;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       rb_sel;
  logic       alu_src_b;
  logic [2:0] alu_op;
  logic       mem_to_reg;
  logic       reg_write;
  logic       halted;
  logic       fault;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_src, ir_write, mem_read, mem_write, rb_sel,
           alu_src_b, alu_op, mem_to_reg, reg_write, halted, fault
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_src, ir_write, mem_read, mem_write, rb_sel,
           alu_src_b, alu_op, mem_to_reg, reg_write, halted, fault
  );
endinterface

// File: rtl/ctrl_fsm_multicycle.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with memory-wait
// handshake and a stall watchdog that faults the core into HALT.
module ctrl_fsm_multicycle #(
  parameter int unsigned STALL_LIMIT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  ctrl_fsm_multicycle_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_ADDI = 4'h5,
    OP_LW   = 4'h6,
    OP_SW   = 4'h7,
    OP_BEQ  = 4'h8,
    OP_JMP  = 4'h9,
    OP_HALT = 4'hF
  } op_t;

  state_t           state, state_nxt;
  op_t              op_q;
  logic [CNT_W-1:0] stall_cnt;
  logic             fault_q;
  logic             set_fault;
  logic             stall_hit;

  logic       pc_write_r, ir_write_r, mem_read_r, mem_write_r, rb_sel_r;
  logic       alu_src_b_r, mem_to_reg_r, reg_write_r, halted_r;
  logic [1:0] pc_src_r;
  logic [2:0] alu_op_r;

  // Current wait cycle is the STALL_LIMIT-th one counting this cycle.
  assign stall_hit = (stall_cnt >= CNT_W'(STALL_LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      op_q      <= OP_NOP;
      stall_cnt <= '0;
      fault_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) op_q <= op_t'(bus.opcode);
      if (set_fault) fault_q <= 1'b1;
      if (state_nxt != state)
        stall_cnt <= '0;
      else if ((state == S_FETCH || state == S_MEM) && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    set_fault    = 1'b0;
    pc_write_r   = 1'b0;
    pc_src_r     = 2'b00;
    ir_write_r   = 1'b0;
    mem_read_r   = 1'b0;
    mem_write_r  = 1'b0;
    rb_sel_r     = 1'b0;
    alu_src_b_r  = 1'b0;
    alu_op_r     = 3'b000;
    mem_to_reg_r = 1'b0;
    reg_write_r  = 1'b0;
    halted_r     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read_r = 1'b1;
        if (bus.mem_ready) begin
          ir_write_r = 1'b1;
          pc_write_r = 1'b1;
          state_nxt  = S_DECODE;
        end else if (stall_hit) begin
          set_fault = 1'b1;
          state_nxt = S_HALT;
        end
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        case (op_q)
          OP_ADD:  state_nxt = S_WB;
          OP_SUB:  begin alu_op_r = 3'b001; state_nxt = S_WB; end
          OP_AND:  begin alu_op_r = 3'b010; state_nxt = S_WB; end
          OP_OR:   begin alu_op_r = 3'b011; state_nxt = S_WB; end
          OP_ADDI: begin alu_src_b_r = 1'b1; state_nxt = S_WB; end
          OP_LW:   begin alu_src_b_r = 1'b1; state_nxt = S_MEM; end
          OP_SW: begin
            alu_src_b_r = 1'b1;
            rb_sel_r    = 1'b1;
            state_nxt   = S_MEM;
          end
          OP_BEQ: begin
            alu_op_r  = 3'b001;
            state_nxt = S_FETCH;
            if (bus.zero) begin
              pc_write_r = 1'b1;
              pc_src_r   = 2'b01;
            end
          end
          OP_JMP: begin
            pc_write_r = 1'b1;
            pc_src_r   = 2'b10;
            state_nxt  = S_FETCH;
          end
          OP_NOP:  state_nxt = S_FETCH;
          OP_HALT: state_nxt = S_HALT;
          default: begin
            set_fault = 1'b1;
            state_nxt = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        if (op_q == OP_SW) begin
          mem_write_r = 1'b1;
          rb_sel_r    = 1'b1;
        end else begin
          mem_read_r = 1'b1;
        end
        if (bus.mem_ready) begin
          state_nxt = (op_q == OP_SW) ? S_FETCH : S_WB;
        end else if (stall_hit) begin
          set_fault = 1'b1;
          state_nxt = S_HALT;
        end
      end
      S_WB: begin
        reg_write_r  = 1'b1;
        mem_to_reg_r = (op_q == OP_LW);
        state_nxt    = S_FETCH;
      end
      S_HALT:  halted_r = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Outputs are masked by rst itself so strobes drop the instant reset asserts.
  assign bus.pc_write   = pc_write_r   & ~rst;
  assign bus.pc_src     = rst ? 2'b00 : pc_src_r;
  assign bus.ir_write   = ir_write_r   & ~rst;
  assign bus.mem_read   = mem_read_r   & ~rst;
  assign bus.mem_write  = mem_write_r  & ~rst;
  assign bus.rb_sel     = rb_sel_r     & ~rst;
  assign bus.alu_src_b  = alu_src_b_r  & ~rst;
  assign bus.alu_op     = rst ? 3'b000 : alu_op_r;
  assign bus.mem_to_reg = mem_to_reg_r & ~rst;
  assign bus.reg_write  = reg_write_r  & ~rst;
  assign bus.halted     = halted_r     & ~rst;
  assign bus.fault      = fault_q      & ~rst;

endmodule

// File: tb/tb_ctrl_fsm_multicycle.sv
// Bench for ctrl_fsm_multicycle: each instruction is expanded into its expected
// cycle-by-cycle output trace from the instruction rules, then replayed against the DUT.
module tb_ctrl_fsm_multicycle;
  localparam int unsigned LIM = 3;

  localparam logic [14:0] B_PCW = 15'h4000;
  localparam logic [14:0] B_IRW = 15'h0800;
  localparam logic [14:0] B_MR  = 15'h0400;
  localparam logic [14:0] B_MW  = 15'h0200;
  localparam logic [14:0] B_RB  = 15'h0100;
  localparam logic [14:0] B_ASB = 15'h0080;
  localparam logic [14:0] B_M2R = 15'h0008;
  localparam logic [14:0] B_RW  = 15'h0004;
  localparam logic [14:0] B_H   = 15'h0002;
  localparam logic [14:0] B_F   = 15'h0001;

  typedef struct {
    string       tag;
    logic        rdy;
    logic        z;
    logic        use_op;
    logic [3:0]  op;
    logic [14:0] exp;
  } cyc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic mfault = 1'b0;
  logic ended_halt;
  cyc_t q[$];

  ctrl_fsm_multicycle_if bus ();

  ctrl_fsm_multicycle #(.STALL_LIMIT(LIM), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [14:0] obs;
  assign obs = {bus.pc_write, bus.pc_src, bus.ir_write, bus.mem_read, bus.mem_write,
                bus.rb_sel, bus.alu_src_b, bus.alu_op, bus.mem_to_reg, bus.reg_write,
                bus.halted, bus.fault};

  task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (pcw,pcs,irw,mr,mw,rb,asb,aop,m2r,rw,h,f)",
               tag, got, want);
    end
  endtask

  function automatic logic [14:0] alu(input logic [2:0] aop);
    return 15'(aop) << 4;
  endfunction

  function automatic logic [14:0] pcs(input logic [1:0] s);
    return 15'(s) << 12;
  endfunction

  task automatic add(input string tag, input logic rdy, input logic z,
                     input logic use_op, input logic [3:0] op, input logic [14:0] e);
    cyc_t c;
    c.tag = tag; c.rdy = rdy; c.z = z; c.use_op = use_op; c.op = op; c.exp = e;
    q.push_back(c);
  endtask

  function automatic logic rb1();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add_halt();
    for (int i = 0; i < 3; i++)
      add("halt", rb1(), rb1(), 1'b0, 4'h0, B_H | (mfault ? B_F : 15'h0));
    ended_halt = 1'b1;
  endtask

  // Expand one instruction into cycles; fw/mw = mem_ready-low cycles before ready.
  task automatic build(input logic [3:0] op, input int unsigned fw,
                       input int unsigned mw, input logic zv);
    ended_halt = 1'b0;
    for (int unsigned i = 0; i < fw && i < LIM; i++) add("fetch_wait", 1'b0, rb1(), 1'b0, op, B_MR);
    if (fw >= LIM) begin mfault = 1'b1; add_halt(); return; end
    add("fetch", 1'b1, rb1(), 1'b0, op, B_MR | B_IRW | B_PCW);
    add("decode", rb1(), rb1(), 1'b1, op, 15'h0);
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4: begin
        add("exec_r", rb1(), rb1(), 1'b0, op, alu(3'(op - 4'h1)));
        add("wb", rb1(), rb1(), 1'b0, op, B_RW);
      end
      4'h5: begin
        add("exec_addi", rb1(), rb1(), 1'b0, op, B_ASB);
        add("wb", rb1(), rb1(), 1'b0, op, B_RW);
      end
      4'h6, 4'h7: begin
        logic        sw;
        logic [14:0] me;
        sw = (op == 4'h7);
        add(sw ? "exec_sw" : "exec_lw", rb1(), rb1(), 1'b0, op, B_ASB | (sw ? B_RB : 15'h0));
        me = sw ? (B_MW | B_RB) : B_MR;
        for (int unsigned i = 0; i < mw && i < LIM; i++) add("mem_wait", 1'b0, rb1(), 1'b0, op, me);
        if (mw >= LIM) begin mfault = 1'b1; add_halt(); return; end
        add("mem", 1'b1, rb1(), 1'b0, op, me);
        if (!sw) add("wb_lw", rb1(), rb1(), 1'b0, op, B_RW | B_M2R);
      end
      4'h8: add(zv ? "beq_taken" : "beq_not", rb1(), zv, 1'b0, op,
                alu(3'b001) | (zv ? (B_PCW | pcs(2'b01)) : 15'h0));
      4'h9: add("exec_jmp", rb1(), rb1(), 1'b0, op, B_PCW | pcs(2'b10));
      4'h0: add("exec_nop", rb1(), rb1(), 1'b0, op, 15'h0);
      4'hF: begin add("exec_halt", rb1(), rb1(), 1'b0, op, 15'h0); add_halt(); end
      default: begin
        add("exec_illegal", rb1(), rb1(), 1'b0, op, 15'h0);
        mfault = 1'b1;
        add_halt();
      end
    endcase
  endtask

  task automatic play_one();
    cyc_t c;
    c = q.pop_front();
    bus.mem_ready = c.rdy;
    bus.zero      = c.z;
    bus.opcode    = c.use_op ? c.op : 4'($urandom);
    #1;
    chk(c.tag, obs, c.exp);
  endtask

  task automatic run_all();
    while (q.size() > 0) begin
      play_one();
      @(negedge clk);
    end
  endtask

  // Asserts rst now, checks outputs drop at once and stay low across an edge,
  // then releases on the following falling edge.
  task automatic reset_now(input string tag);
    rst = 1'b1;
    #1;
    chk(tag, obs, 15'h0);
    @(posedge clk);
    #1;
    chk("rst_hold", obs, 15'h0);
    @(negedge clk);
    rst = 1'b0;
    mfault = 1'b0;
    q.delete();
  endtask

  initial begin
    bus.opcode = 4'h0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    reset_now("rst_init");

    build(4'h1, 0, 0, 1'b0); run_all();          // ADD
    build(4'h6, 0, 0, 1'b0); run_all();          // LW
    build(4'h7, 0, 0, 1'b0); run_all();          // SW
    build(4'h8, 0, 0, 1'b1); run_all();          // BEQ taken
    build(4'h8, 0, 0, 1'b0); run_all();          // BEQ not taken
    build(4'h9, 1, 0, 1'b0); run_all();          // JMP
    build(4'h6, 2, 2, 1'b0); run_all();          // ready on limit cycle wins
    build(4'h1, 3, 0, 1'b0); run_all();          // fetch stall fault
    reset_now("rst_after_stall");
    build(4'hA, 0, 0, 1'b0); run_all();          // illegal
    reset_now("rst_after_illegal");
    build(4'h6, 0, 3, 1'b0); run_all();          // mem stall fault
    reset_now("rst_after_mem_stall");

    // Reset during SW MEM: first two cycles of the trace would be the mem waits
    build(4'h7, 0, 2, 1'b0);
    for (int i = 0; i < 3; i++) begin play_one(); @(negedge clk); end
    play_one();
    reset_now("rst_mid_sw_mem");
    build(4'h0, 0, 0, 1'b0); run_all();          // restart in FETCH, fault clear

    for (int k = 0; k < 300; k++) begin
      logic [3:0]  op;
      int unsigned fw, mw;
      op = 4'($urandom_range(0, 15));
      if ((op > 4'h9) && ($urandom_range(0, 3) != 0)) op = 4'($urandom_range(0, 9));
      fw = ($urandom_range(0, 9) == 0) ? LIM : $urandom_range(0, LIM - 1);
      mw = ($urandom_range(0, 9) == 0) ? LIM : $urandom_range(0, LIM - 1);
      build(op, fw, mw, rb1());
      if ($urandom_range(0, 19) == 0 && q.size() > 2) begin
        int unsigned n;
        n = $urandom_range(1, q.size() - 1);
        for (int unsigned i = 0; i < n; i++) begin play_one(); @(negedge clk); end
        play_one();
        reset_now("rst_random_abort");
      end else begin
        run_all();
        if (ended_halt) reset_now("rst_after_halt");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm_multicycle.md
Name: ctrl_fsm_multicycle

Overview:
- Multi-cycle control unit of the 16-bit RISC core.
- Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and drives all datapath enables and selects.
- Drives `rb_sel`, the select of the 4-bit 2:1 register-address mux. That mux picks read-port-B address: `instr[3:0]` (sel=0) or `instr[11:8]` (sel=1, store data register).
- Includes a memory-wait handshake and a stall watchdog.

Parameters:
- STALL_LIMIT, 15, max consecutive cycles waiting on `mem_ready` in FETCH or MEM before fault (range 1..255).
- CNT_W, 8, width of the stall counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- opcode  input  4  `instr[15:12]` from the instruction register; sampled in DECODE
- zero  input  1  ALU zero flag; sampled in EXEC for BEQ
- mem_ready  input  1  memory completes the current access this cycle
- pc_write  output  1  PC load enable
- pc_src  output  2  PC source: 00 = PC+1, 01 = branch target, 10 = jump target
- ir_write  output  1  instruction register load enable
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- rb_sel  output  1  register-address mux select (1 only for SW)
- alu_src_b  output  1  ALU B operand: 0 = register, 1 = sign-extended `imm4`
- alu_op  output  3  000 ADD, 001 SUB, 010 AND, 011 OR
- mem_to_reg  output  1  writeback source: 0 = ALU result, 1 = memory data
- reg_write  output  1  register file write enable
- halted  output  1  core stopped (HALT executed or fault)
- fault  output  1  sticky; set on illegal opcode or stall timeout

Behaviour:
- Opcode map:
  - 0000 NOP; 0001 ADD; 0010 SUB; 0011 AND; 0100 OR
  - 0101 ADDI; 0110 LW; 0111 SW; 1000 BEQ; 1001 JMP; 1111 HALT
  - All other opcodes are illegal.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Reset:
  - State goes to FETCH; opcode latch, stall counter and `fault` go to 0.
  - All outputs are forced to 0 while `rst`=1, regardless of state.
  - Reset mid-instruction aborts it; no write strobe may be asserted in the cycle `rst` falls.
- FETCH:
  - Assert `mem_read`.
  - When `mem_ready`=1: assert `ir_write`, `pc_write` with `pc_src`=00; go to DECODE.
  - Otherwise stay in FETCH and increment the stall counter.
- DECODE: latch `opcode`; all strobes 0; go to EXEC.
- EXEC (outputs from the latched opcode):
  - R-type (0001–0100): `alu_src_b`=0, `alu_op` per the map; next WB.
  - ADDI: `alu_src_b`=1, `alu_op`=ADD; next WB.
  - LW: `alu_src_b`=1, `alu_op`=ADD (address); next MEM.
  - SW: `alu_src_b`=1, `alu_op`=ADD (address), `rb_sel`=1; next MEM.
  - BEQ: `alu_op`=SUB, `alu_src_b`=0. If `zero`=1, assert `pc_write` with `pc_src`=01. Next FETCH.
  - JMP: `pc_write`, `pc_src`=10; next FETCH.
  - NOP: next FETCH.
  - HALT: next HALT.
  - Illegal: set `fault`, next HALT.
- MEM:
  - LW: `mem_read`=1; on `mem_ready`, go to WB.
  - SW: `mem_write`=1, `rb_sel`=1 (held stable for the whole state); on `mem_ready`, go to FETCH.
  - Without `mem_ready`, stay in MEM and increment the stall counter.
- WB:
  - `reg_write`=1 for exactly one cycle; `mem_to_reg`=1 only for LW.
  - Next FETCH.
- HALT: `halted`=1; all strobes 0; exits only by reset.
- Stall watchdog:
  - Counter clears on every state transition.
  - If it reaches STALL_LIMIT while still waiting (FETCH or MEM), set `fault` and go to HALT.
  - A `mem_ready` arriving in the same cycle the limit is reached wins: normal transition, no fault.
  - Counter saturates; it never wraps.
- Cycle counts with `mem_ready` tied to 1:
  - R-type / ADDI: 4; LW: 5; SW: 4; BEQ / JMP / NOP: 3.
- `rb_sel` is 0 in every state except EXEC and MEM of SW.
- `mem_read` and `mem_write` are never both 1.

Test Plan:
- ADD, `mem_ready`=1: states F,D,E,WB. `reg_write` is high only in cycle 4 with `mem_to_reg`=0; `alu_op`=000 in cycle 3.
- LW, then SW, `mem_ready`=1:
  - LW takes 5 cycles; `mem_to_reg`=1 in WB.
  - SW: `rb_sel`=1 in EXEC and MEM; `mem_write` high for 1 cycle; `reg_write` never asserted.
- BEQ with `zero`=1 then `zero`=0: `pc_write`=1 with `pc_src`=01 in EXEC only for the taken case; both take 3 cycles.
- FETCH with `mem_ready` held 0, STALL_LIMIT=3: fault and HALT after 3 wait cycles. Repeat with `mem_ready` rising on the 3rd wait cycle: no fault, DECODE next.
- Opcode 1010 (illegal): `fault`=1 and `halted`=1 one cycle after EXEC; both remain until `rst`.
- `rst` pulsed during MEM of SW: `mem_write` drops immediately (asynchronously). After release, the FSM restarts in FETCH with `fault`=0.
